keypad_event_queue: RTL and testbench
=====================================

KEYPAD_EVENT_QUEUE -- requirements
Module: keypad_event_queue

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 100000, the consecutive cycles a synchronized key code must hold before it is accepted (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter DEPTH, default 4, the event FIFO depth; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single system clock (100 MHz); all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_raw, input, 4, the code from keypad_decoder (DecodeOut); asynchronous to this logic.
REQ-006 SHALL have port ev_ready, input, 1, the consumer (music_player / wave_display_top) accepts the head event.
REQ-007 SHALL have port clear_ovf, input, 1, a single-cycle pulse that clears the overflow flag.
REQ-008 SHALL have port ev_valid, output, 1, the FIFO is non-empty.
REQ-009 SHALL have port ev_key, output, 4, the head event code, valid while ev_valid=1.
REQ-010 SHALL have port key_stable, output, 4, the current debounced key code.
REQ-011 SHALL have port ev_count, output, $clog2(DEPTH)+1, the number of queued events.
REQ-012 SHALL have port overflow, output, 1, a sticky flag: an event was dropped.

Function
REQ-013 SHALL pass key_raw through a two-flop synchronizer (key_sync) before any other use.
REQ-014 SHALL hold a candidate register cand and a stability counter cnt (ceil(log2(STABLE_CYCLES)) bits).
REQ-015 SHALL, when key_sync != cand, load cand<=key_sync and cnt<=0 in the same cycle.
REQ-016 SHALL, when key_sync == cand, increment cnt and saturate at STABLE_CYCLES-1.
REQ-017 SHALL, in the cycle cnt==STABLE_CYCLES-1, key_sync==cand and cand!=key_stable, load key_stable<=cand and assert an internal push for exactly one cycle.
REQ-018 SHALL NOT push when a stable code equals key_stable; holding one key produces exactly one event.
REQ-019 SHALL accept a change held at key_raw with push occurring STABLE_CYCLES+2 cycles after the first clk edge that samples the new value.
REQ-020 SHALL restart qualification from zero on any glitch shorter than STABLE_CYCLES, with no event and key_stable unchanged.
REQ-021 SHALL implement the FIFO as first-word fall-through: ev_key = the oldest entry, with ev_valid = (ev_count != 0) combinationally from registered state.
REQ-022 SHALL pop when ev_valid && ev_ready; ev_ready while empty SHALL have no effect.
REQ-023 SHALL make a pushed event visible on ev_valid/ev_key on the cycle after the push.
REQ-024 SHALL, on simultaneous push and pop, keep ev_count unchanged and write the new event behind the remaining entries; this is legal when full and SHALL NOT set overflow.
REQ-025 SHALL, on push while full with no pop, drop the new event, leave the queue unchanged and set overflow<=1.
REQ-026 SHALL hold the ev_key of a valid, un-popped head stable across cycles.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL clear overflow on clear_ovf; if clear_ovf and a new overflow occur in the same cycle, set SHALL win.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force: synchronizer flops=0, cand=0, cnt=0, key_stable=0, pointers=0, ev_count=0, ev_valid=0, overflow=0; ev_key SHALL read 0.
REQ-030 SHALL, on reset asserted mid-qualification or with events queued, discard all pending state and generate no event on release.
REQ-031 SHALL, after reset release with key_raw=0, generate no event; with key_raw!=0, generate one event after qualification per REQ-019.

Verification (STABLE_CYCLES=4, DEPTH=4)
REQ-032 SHALL cover: key_raw 0->5 held -> push 6 cycles after first sample; ev_valid=1, ev_key=5, key_stable=5 next cycle; exactly one event while held.
REQ-033 SHALL cover: key_raw 5->9 for 3 cycles then back to 5 -> no event, key_stable stays 5.
REQ-034 SHALL cover: ev_ready=0 and 5 qualified changes (1,2,3,4,6) -> ev_count=4, overflow=1, pops yield 1,2,3,4, then ev_valid=0.
REQ-035 SHALL cover: full queue, push and pop in the same cycle -> ev_count stays 4, overflow stays 0, order preserved.
REQ-036 SHALL cover: clear_ovf in the same cycle as a dropped push -> overflow=1; a later clear_ovf alone -> overflow=0.
REQ-037 SHALL cover: reset_n pulsed low asynchronously with 2 events queued and cnt=2 -> all outputs 0 immediately; no event after release with key_raw=0.

Source files
------------

// File: rtl/keypad_event_queue.sv
// Debounces an asynchronous 4-bit key code and queues each newly accepted code in a first-word-fall-through FIFO.
// Push lands STABLE_CYCLES+2 edges after the first sample; a push into a full queue without a pop is dropped and raises overflow.
module keypad_event_queue #(
  parameter int STABLE_CYCLES = 100000,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               key_raw,
  input  logic                     ev_ready,
  input  logic                     clear_ovf,
  output logic                     ev_valid,
  output logic [3:0]               ev_key,
  output logic [3:0]               key_stable,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);

  localparam int CW   = $clog2(STABLE_CYCLES);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [CNTW-1:0] CNT_INC = CNTW'(1);
  localparam logic [CNTW-1:0] FULL_LVL = CNTW'(DEPTH);

  logic [3:0]    sync1;
  logic [3:0]    key_sync;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      key_sync <= '0;
    end else begin
      sync1    <= key_raw;
      key_sync <= sync1;
    end
  end

  // A code is accepted once it has been seen unchanged for STABLE_CYCLES cycles.
  assign push = (key_sync == cand) && (cnt == CNT_MAX) && (cand != key_stable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand       <= '0;
      cnt        <= '0;
      key_stable <= '0;
    end else begin
      if (key_sync != cand) begin
        cand <= key_sync;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      if (push) key_stable <= cand;
    end
  end

  assign ev_valid = (ev_count != '0);
  assign full     = (ev_count == FULL_LVL);
  assign pop      = ev_valid && ev_ready;
  // When full, a concurrent pop frees the slot the write pointer already aims at.
  assign wr_en    = push && (!full || pop);
  assign ev_key   = ev_valid ? mem[rd_ptr] : 4'h0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !pop)      ev_count <= ev_count + CNT_INC;
      else if (!wr_en && pop) ev_count <= ev_count - CNT_INC;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_ovf)       overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Scoreboard bench for keypad_event_queue with STABLE_CYCLES=4, DEPTH=4.
module tb_keypad_event_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_raw;
  logic       ev_ready;
  logic       clear_ovf;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic [3:0] key_stable;
  logic [2:0] ev_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  keypad_event_queue #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .ev_ready   (ev_ready),
    .clear_ovf  (clear_ovf),
    .ev_valid   (ev_valid),
    .ev_key     (ev_key),
    .key_stable (key_stable),
    .ev_count   (ev_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a code long enough to qualify; record it if it should reach the queue.
  task automatic qualify(input logic [3:0] k, input bit expect_push);
    key_raw = k;
    if (expect_push) exp_q.push_back(k);
    tick(9);
  endtask

  task automatic drain(input int n);
    ev_ready = 1'b1;
    tick(n);
    ev_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
      else check("pop_key", {28'd0, ev_key}, {28'd0, exp_q.pop_front()});
    end
  end

  initial begin
    reset_n   = 1'b0;
    key_raw   = 4'h0;
    ev_ready  = 1'b0;
    clear_ovf = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_key", {28'd0, ev_key}, 32'd0);
    check("rst_stable", {28'd0, key_stable}, 32'd0);
    check("rst_count", {29'd0, ev_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(12);
    check("idle_no_event", {31'd0, ev_valid}, 32'd0);

    // First accepted code: registered on the 7th edge after it is applied.
    key_raw = 4'h5;
    exp_q.push_back(4'h5);
    tick(6);
    check("lat_not_yet", {31'd0, ev_valid}, 32'd0);
    check("lat_stable_old", {28'd0, key_stable}, 32'd0);
    tick(1);
    check("lat_valid", {31'd0, ev_valid}, 32'd1);
    check("lat_key", {28'd0, ev_key}, 32'd5);
    check("lat_stable", {28'd0, key_stable}, 32'd5);
    tick(10);
    check("hold_one_event", {29'd0, ev_count}, 32'd1);
    check("hold_key_steady", {28'd0, ev_key}, 32'd5);
    drain(1);
    check("drained_empty", {31'd0, ev_valid}, 32'd0);

    // Short glitch to 9 then back to the already-stable 5.
    key_raw = 4'h9;
    tick(3);
    key_raw = 4'h5;
    tick(12);
    check("glitch_no_event", {31'd0, ev_valid}, 32'd0);
    check("glitch_stable", {28'd0, key_stable}, 32'd5);

    // Overflow: four fit, the fifth is dropped.
    qualify(4'h1, 1'b1);
    qualify(4'h2, 1'b1);
    qualify(4'h3, 1'b1);
    qualify(4'h4, 1'b1);
    check("fill_count", {29'd0, ev_count}, 32'd4);
    check("fill_no_ovf", {31'd0, overflow}, 32'd0);
    qualify(4'h6, 1'b0);
    check("ovf_count", {29'd0, ev_count}, 32'd4);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_stable", {28'd0, key_stable}, 32'd6);
    drain(4);
    check("ovf_drained", {31'd0, ev_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full queue with push and pop on the same edge.
    qualify(4'h1, 1'b1);
    qualify(4'h2, 1'b1);
    qualify(4'h3, 1'b1);
    qualify(4'h4, 1'b1);
    key_raw = 4'h7;
    exp_q.push_back(4'h7);
    tick(6);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("pp_count", {29'd0, ev_count}, 32'd4);
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    tick(3);
    drain(4);
    check("pp_drained", {29'd0, ev_count}, 32'd0);

    // Clear and drop in the same cycle: set must win.
    qualify(4'h1, 1'b1);
    qualify(4'h2, 1'b1);
    qualify(4'h3, 1'b1);
    qualify(4'h4, 1'b1);
    key_raw = 4'h8;
    tick(6);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("clr_vs_set", {31'd0, overflow}, 32'd1);
    check("clr_vs_set_cnt", {29'd0, ev_count}, 32'd4);
    tick(3);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check("clr_alone", {31'd0, overflow}, 32'd0);

    // Leave two events queued, start qualifying a new code, then reset mid-cycle.
    drain(2);
    check("pre_rst_count", {29'd0, ev_count}, 32'd2);
    key_raw = 4'hA;
    tick(5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ev_valid}, 32'd0);
    check("arst_key", {28'd0, ev_key}, 32'd0);
    check("arst_count", {29'd0, ev_count}, 32'd0);
    check("arst_stable", {28'd0, key_stable}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    key_raw = 4'h0;
    tick(2);
    reset_n = 1'b1;
    tick(15);
    check("post_rst_no_event", {31'd0, ev_valid}, 32'd0);
    check("post_rst_stable", {28'd0, key_stable}, 32'd0);

    // After reset, a held non-zero code qualifies exactly once.
    key_raw = 4'h3;
    exp_q.push_back(4'h3);
    tick(7);
    check("post_rst_event", {31'd0, ev_valid}, 32'd1);
    drain(1);
    tick(10);
    check("post_rst_single", {31'd0, ev_valid}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
